// File: rtl/lfu_pkg.sv
// Shared types and sizing for the LFU buffer allocation controller.
package lfu_pkg;

  localparam int NUM_BUF   = 4;
  localparam int BUF_IDX_W = 2;
  localparam int DEF_TAG_W = 8;
  localparam int DEF_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FILL,
    RESP
  } lfu_state_e;

endpackage

// File: rtl/lfu_victim_sel.sv
// Combinational replacement choice: first invalid entry, else the smallest
// frequency count, with the lowest index winning every tie.
module lfu_victim_sel
  import lfu_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic [NUM_BUF-1:0]            valid,
  input  logic [NUM_BUF-1:0][CNT_W-1:0] cnt,
  output logic [BUF_IDX_W-1:0]          victim
);

  logic             found_inv;
  logic [CNT_W-1:0] best_cnt;

  // Scanning downward lets the lowest-index invalid entry overwrite the rest.
  always_comb begin
    victim    = '0;
    found_inv = 1'b0;
    best_cnt  = cnt[0];
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim    = BUF_IDX_W'(i);
        found_inv = 1'b1;
      end
    end
    if (!found_inv) begin
      for (int i = 1; i < NUM_BUF; i++) begin
        if (cnt[i] < best_cnt) begin
          best_cnt = cnt[i];
          victim   = BUF_IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/lfu_buf_alloc_ctrl.sv
// Tag lookup, LFU frequency tracking and fill/response sequencing for a
// four-entry buffer pool.
module lfu_buf_alloc_ctrl
  import lfu_pkg::*;
#(
  parameter int TAG_W = DEF_TAG_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_vld,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 req_rdy,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic [BUF_IDX_W-1:0] rsp_buf,
  output logic                 rsp_hit,
  output logic                 fill_req,
  output logic [BUF_IDX_W-1:0] fill_buf,
  output logic [TAG_W-1:0]     fill_tag,
  input  logic                 fill_done,
  input  logic                 flush
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_AGED = CNT_MAX - (CNT_MAX >> 1);

  lfu_state_e                      state_q;
  logic [NUM_BUF-1:0]              valid_q;
  logic [NUM_BUF-1:0][TAG_W-1:0]   tag_q;
  logic [NUM_BUF-1:0][CNT_W-1:0]   cnt_q;
  logic [TAG_W-1:0]                req_tag_q;

  logic                            rsp_vld_q;
  logic [BUF_IDX_W-1:0]            rsp_buf_q;
  logic                            rsp_hit_q;
  logic                            fill_req_q;
  logic [BUF_IDX_W-1:0]            fill_buf_q;
  logic [TAG_W-1:0]                fill_tag_q;

  logic                            hit;
  logic [BUF_IDX_W-1:0]            hit_idx;
  logic [BUF_IDX_W-1:0]            victim;
  logic [NUM_BUF-1:0][CNT_W-1:0]   cnt_hit_next;

  assign req_rdy  = (state_q == IDLE) && !flush;
  assign rsp_vld  = rsp_vld_q;
  assign rsp_buf  = rsp_buf_q;
  assign rsp_hit  = rsp_hit_q;
  assign fill_req = fill_req_q;
  assign fill_buf = fill_buf_q;
  assign fill_tag = fill_tag_q;

  // Downward scan so a duplicate valid tag resolves to the lowest index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == req_tag_q)) begin
        hit     = 1'b1;
        hit_idx = BUF_IDX_W'(i);
      end
    end
  end

  // A hit on a saturated counter halves every valid count before re-seeding
  // the hit entry, so the relative ordering keeps tracking recent use.
  always_comb begin
    cnt_hit_next = cnt_q;
    if (cnt_q[hit_idx] != CNT_MAX) begin
      cnt_hit_next[hit_idx] = cnt_q[hit_idx] + CNT_W'(1);
    end else begin
      for (int i = 0; i < NUM_BUF; i++) begin
        if (valid_q[i]) begin
          cnt_hit_next[i] = cnt_q[i] >> 1;
        end
      end
      cnt_hit_next[hit_idx] = CNT_AGED;
    end
  end

  lfu_victim_sel #(
    .CNT_W (CNT_W)
  ) u_victim_sel (
    .valid  (valid_q),
    .cnt    (cnt_q),
    .victim (victim)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      tag_q      <= '0;
      cnt_q      <= '0;
      req_tag_q  <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_buf_q  <= '0;
      rsp_hit_q  <= 1'b0;
      fill_req_q <= 1'b0;
      fill_buf_q <= '0;
      fill_tag_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            valid_q <= '0;
            cnt_q   <= '0;
          end else if (req_vld) begin
            req_tag_q <= req_tag;
            state_q   <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (hit) begin
            cnt_q     <= cnt_hit_next;
            rsp_vld_q <= 1'b1;
            rsp_buf_q <= hit_idx;
            rsp_hit_q <= 1'b1;
            state_q   <= RESP;
          end else begin
            fill_req_q <= 1'b1;
            fill_buf_q <= victim;
            fill_tag_q <= req_tag_q;
            state_q    <= FILL;
          end
        end

        FILL: begin
          if (fill_done) begin
            tag_q[fill_buf_q]   <= fill_tag_q;
            valid_q[fill_buf_q] <= 1'b1;
            cnt_q[fill_buf_q]   <= CNT_W'(1);
            fill_req_q          <= 1'b0;
            rsp_vld_q           <= 1'b1;
            rsp_buf_q           <= fill_buf_q;
            rsp_hit_q           <= 1'b0;
            state_q             <= RESP;
          end
        end

        RESP: begin
          if (rsp_rdy) begin
            rsp_vld_q <= 1'b0;
            state_q   <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfu_buf_alloc_ctrl.sv
// Directed scoreboard bench for lfu_buf_alloc_ctrl with a behavioural LFU model.
module tb_lfu_buf_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rst, req_vld, req_rdy, rsp_vld, rsp_rdy, rsp_hit;
  logic       fill_req, fill_done, flush;
  logic [7:0] req_tag, fill_tag;
  logic [1:0] rsp_buf, fill_buf;

  typedef struct packed {
    logic [1:0] buf_n;
    logic       hit;
  } exp_t;

  exp_t       sb[$];
  logic       m_valid[4];
  logic [7:0] m_tag[4];
  logic [1:0] m_cnt[4];
  logic       pend_hit;
  logic [1:0] pend_victim;
  logic [7:0] pend_tag;
  int         checks = 0;
  int         errors = 0;

  lfu_buf_alloc_ctrl #(.TAG_W(8), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_tag   (req_tag),
    .req_rdy   (req_rdy),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp_buf   (rsp_buf),
    .rsp_hit   (rsp_hit),
    .fill_req  (fill_req),
    .fill_buf  (fill_buf),
    .fill_tag  (fill_tag),
    .fill_done (fill_done),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_cnt();
    return {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
  endfunction

  function automatic logic [3:0] model_valid();
    return {m_valid[3], m_valid[2], m_valid[1], m_valid[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 8'h00;
      m_cnt[i]   = 2'd0;
    end
  endtask

  // Predicts the outcome, queues it, then presents the request (entered and left at a negedge).
  task automatic applyStimulus(input logic [7:0] tag);
    exp_t e;
    int   idx = 0;
    int   k = 0;
    logic found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && m_valid[i] && m_tag[i] == tag) begin
        found = 1'b1;
        idx   = i;
      end
    end
    if (found) begin
      if (m_cnt[idx] == 2'd3) begin
        for (int j = 0; j < 4; j++) if (m_valid[j]) m_cnt[j] = m_cnt[j] >> 1;
        m_cnt[idx] = 2'd2;
      end else begin
        m_cnt[idx] = m_cnt[idx] + 2'd1;
      end
      e.buf_n = 2'(idx);
    end else begin
      logic got = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!got && !m_valid[i]) begin
          got = 1'b1;
          idx = i;
        end
      end
      if (!got) begin
        idx = 0;
        for (int i = 1; i < 4; i++) if (m_cnt[i] < m_cnt[idx]) idx = i;
      end
      e.buf_n = 2'(idx);
    end
    e.hit       = found;
    pend_hit    = found;
    pend_victim = 2'(idx);
    pend_tag    = tag;
    sb.push_back(e);
    while (!req_rdy && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("req_rdy_idle", 32'(req_rdy), 32'd1);
    req_vld = 1'b1;
    req_tag = tag;
    @(posedge clk);
    @(negedge clk);
    req_vld = 1'b0;
    checkOutput("req_rdy_busy", 32'(req_rdy), 32'd0);
  endtask

  task automatic wait_fill_req();
    int k = 0;
    while (!fill_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("fill_req", 32'(fill_req), 32'd1);
    checkOutput("fill_buf", 32'(fill_buf), 32'(pend_victim));
    checkOutput("fill_tag", 32'(fill_tag), 32'(pend_tag));
  endtask

  task automatic finish_fill();
    if (!pend_hit) begin
      wait_fill_req();
      repeat (2) @(negedge clk);
      checkOutput("fill_buf_hold", 32'(fill_buf), 32'(pend_victim));
      checkOutput("fill_req_hold", 32'(fill_req), 32'd1);
      fill_done = 1'b1;
      @(negedge clk);
      fill_done = 1'b0;
      checkOutput("fill_req_drop", 32'(fill_req), 32'd0);
      m_tag[pend_victim]   = pend_tag;
      m_valid[pend_victim] = 1'b1;
      m_cnt[pend_victim]   = 2'd1;
    end
  endtask

  task automatic finish_resp(input int hold);
    exp_t e;
    int   k = 0;
    while (!rsp_vld && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rsp_vld", 32'(rsp_vld), 32'd1);
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput("rsp_buf", 32'(rsp_buf), 32'(e.buf_n));
    checkOutput("rsp_hit", 32'(rsp_hit), 32'(e.hit));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("rsp_vld_hold", 32'(rsp_vld), 32'd1);
      checkOutput("rsp_buf_hold", 32'(rsp_buf), 32'(e.buf_n));
      checkOutput("req_rdy_resp", 32'(req_rdy), 32'd0);
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    checkOutput("rsp_vld_drop", 32'(rsp_vld), 32'd0);
    checkOutput("req_rdy_after", 32'(req_rdy), 32'd1);
    checkOutput("cnt_state", 32'(dut.cnt_q), 32'(model_cnt()));
    checkOutput("valid_state", 32'(dut.valid_q), 32'(model_valid()));
  endtask

  task automatic run_txn(input logic [7:0] tag, input int hold);
    applyStimulus(tag);
    finish_fill();
    finish_resp(hold);
  endtask

  initial begin
    rst = 1'b1; req_vld = 1'b0; req_tag = 8'h00; rsp_rdy = 1'b0;
    fill_done = 1'b0; flush = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");
    checkOutput("rst_req_rdy", 32'(req_rdy), 32'd1);
    checkOutput("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    checkOutput("rst_rsp_buf", 32'(rsp_buf), 32'd0);
    checkOutput("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    checkOutput("rst_fill_req", 32'(fill_req), 32'd0);
    checkOutput("rst_fill_buf", 32'(fill_buf), 32'd0);
    checkOutput("rst_fill_tag", 32'(fill_tag), 32'd0);
    checkOutput("rst_cnt", 32'(dut.cnt_q), 32'd0);

    $display("[TB] fill four entries");
    run_txn(8'h11, 0);
    run_txn(8'h22, 0);
    run_txn(8'h33, 0);
    run_txn(8'h44, 0);

    $display("[TB] hits then LFU victim");
    run_txn(8'h11, 0);
    run_txn(8'h11, 0);
    run_txn(8'h22, 0);
    run_txn(8'h44, 0);
    run_txn(8'h55, 0);

    $display("[TB] saturation aging");
    run_txn(8'h11, 0);

    $display("[TB] equal counters tie-break");
    run_txn(8'h22, 0);
    run_txn(8'h55, 0);
    run_txn(8'h55, 0);
    run_txn(8'h44, 0);
    checkOutput("cnt_all_two", 32'(dut.cnt_q), 32'h0000_00AA);
    run_txn(8'h66, 0);

    $display("[TB] response backpressure");
    run_txn(8'h22, 5);

    $display("[TB] flush beats request");
    flush   = 1'b1;
    req_vld = 1'b1;
    req_tag = 8'h11;
    #1;
    checkOutput("flush_req_rdy", 32'(req_rdy), 32'd0);
    @(negedge clk);
    flush   = 1'b0;
    req_vld = 1'b0;
    #1;
    checkOutput("flush_idle", 32'(req_rdy), 32'd1);
    checkOutput("flush_valid", 32'(dut.valid_q), 32'd0);
    checkOutput("flush_cnt", 32'(dut.cnt_q), 32'd0);
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 2'd0;
    end
    @(negedge clk);
    run_txn(8'h11, 0);

    $display("[TB] reset during fill");
    applyStimulus(8'h77);
    wait_fill_req();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    model_reset();
    checkOutput("rstfill_fill_req", 32'(fill_req), 32'd0);
    checkOutput("rstfill_req_rdy", 32'(req_rdy), 32'd1);
    checkOutput("rstfill_rsp_vld", 32'(rsp_vld), 32'd0);
    fill_done = 1'b1;
    @(negedge clk);
    fill_done = 1'b0;
    @(negedge clk);
    checkOutput("stray_fill_req", 32'(fill_req), 32'd0);
    checkOutput("stray_rsp_vld", 32'(rsp_vld), 32'd0);
    checkOutput("stray_valid", 32'(dut.valid_q), 32'd0);
    run_txn(8'h11, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
